// File: rtl/rf_pkg.sv
// Shared constants and helpers for the rf_sb register file / scoreboard.
package rf_pkg;

  localparam int RF_DATA_W     = 32;
  localparam int RF_ADDR_W     = 5;
  localparam int RF_ZERO_IDX   = 0;
  // Widest index the popcount helper supports (256 registers).
  localparam int RF_MAX_ADDR_W = 8;
  localparam int RF_MAX_DEPTH  = 1 << RF_MAX_ADDR_W;

  // Number of set bits; narrower vectors are zero-extended by the caller.
  function automatic int unsigned rf_popcount(input logic [RF_MAX_DEPTH-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < RF_MAX_DEPTH; i++) begin
      c += 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/rf_sb_if.sv
// Decode/issue/writeback bus of the rf_sb register file.
// master = pipeline control side, slave = register file.
interface rf_sb_if
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);

  logic [ADDR_W-1:0] rR1;
  logic [DATA_W-1:0] rD1;
  logic              rs1_busy;
  logic [ADDR_W-1:0] rR2;
  logic [DATA_W-1:0] rD2;
  logic              rs2_busy;
  logic              we;
  logic [ADDR_W-1:0] wR;
  logic [DATA_W-1:0] wD;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd;
  logic              flush;
  logic [ADDR_W:0]   busy_cnt;

  modport master (
    output rR1, rR2, we, wR, wD, iss_valid, iss_rd, flush,
    input  rD1, rs1_busy, rD2, rs2_busy, busy_cnt
  );

  modport slave (
    input  rR1, rR2, we, wR, wD, iss_valid, iss_rd, flush,
    output rD1, rs1_busy, rD2, rs2_busy, busy_cnt
  );

endinterface

// File: rtl/rf_busy_table.sv
// Per-register busy scoreboard: set on issue, cleared on writeback,
// wiped by flush. Keeps a registered count of busy entries.
module rf_busy_table
  import rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rr1,
  input  logic [ADDR_W-1:0] rr2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int   DEPTH = 1 << ADDR_W;
  localparam logic ZR    = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] IDX0 = ADDR_W'(RF_ZERO_IDX);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  // Next busy vector: flush wipes everything; otherwise the issue set is
  // applied after the writeback clear so a new producer wins on a tie.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (we) busy_nxt[wr] = 1'b0;
      if (iss_valid && !(ZR && (iss_rd == IDX0))) busy_nxt[iss_rd] = 1'b1;
    end
  end

  // Busy bits and their population count advance together.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= (ADDR_W+1)'(rf_popcount(RF_MAX_DEPTH'(busy_nxt)));
    end
  end

  assign rs1_busy = busy[rr1] & ~(ZR && (rr1 == IDX0));
  assign rs2_busy = busy[rr2] & ~(ZR && (rr2 == IDX0));

endmodule

// File: rtl/rf_sb.sv
// rf_sb: 2-read/1-write register file with integrated busy scoreboard
// for the pipelined core.
// Optional: define RF_BYPASS_EN to forward same-cycle writeback data to
// the read ports (and report the forwarded operand as not busy).
module rf_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input logic    clk,
  input logic    rst,
  rf_sb_if.slave bus
);

  localparam int   DEPTH = 1 << ADDR_W;
  localparam logic ZR    = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] IDX0 = ADDR_W'(RF_ZERO_IDX);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_ok;
  logic              rd1_zero;
  logic              rd2_zero;
  logic              byp1;
  logic              byp2;
  logic              bt_rs1_busy;
  logic              bt_rs2_busy;

  assign wr_ok    = bus.we && !(ZR && (bus.wR == IDX0));
  assign rd1_zero = ZR && (bus.rR1 == IDX0);
  assign rd2_zero = ZR && (bus.rR2 == IDX0);

`ifdef RF_BYPASS_EN
  assign byp1 = wr_ok && (bus.wR == bus.rR1);
  assign byp2 = wr_ok && (bus.wR == bus.rR2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // Data array: cleared on reset, written on writeback (r0 protected).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.wR] <= bus.wD;
    end
  end

  assign bus.rD1 = rd1_zero ? '0 : (byp1 ? bus.wD : regs[bus.rR1]);
  assign bus.rD2 = rd2_zero ? '0 : (byp2 ? bus.wD : regs[bus.rR2]);

  assign bus.rs1_busy = bt_rs1_busy & ~byp1;
  assign bus.rs2_busy = bt_rs2_busy & ~byp2;

  rf_busy_table #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_busy (
    .clk       (clk),
    .rst       (rst),
    .we        (bus.we),
    .wr        (bus.wR),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .flush     (bus.flush),
    .rr1       (bus.rR1),
    .rr2       (bus.rR2),
    .rs1_busy  (bt_rs1_busy),
    .rs2_busy  (bt_rs2_busy),
    .busy_cnt  (bus.busy_cnt)
  );

endmodule

// File: tb/tb_rf_sb.sv
// Directed bench for rf_sb (DATA_W=32, ADDR_W=5, ZERO_REG=1).
`timescale 1ns/1ps
module tb_rf_sb;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rf_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  rf_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.iss_valid = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] rd);
    bus.iss_valid = 1'b1; bus.iss_rd = rd;
    tick();
    bus.iss_valid = 1'b0;
  endtask

  initial begin
    bus.rR1 = '0; bus.rR2 = '0; bus.wR = '0; bus.wD = '0; bus.iss_rd = '0;
    idle();
    tick(); tick();
    rst = 1'b0;
    bus.rR1 = 5'd3;
    #1;
    chk("rst_cnt", 64'(bus.busy_cnt), 64'd0);
    chk("rst_rd1", 64'(bus.rD1), 64'd0);
    chk("rst_busy1", 64'(bus.rs1_busy), 64'd0);

    // Reset clears data and busy; rst overrides a concurrent write.
    bus.we = 1'b1; bus.wR = 5'd5; bus.wD = 32'hDEADBEEF;
    tick(); idle();
    bus.rR1 = 5'd5; #1;
    chk("wr_r5", 64'(bus.rD1), 64'hDEADBEEF);
    issue(5'd6); #1;
    chk("cnt_r6", 64'(bus.busy_cnt), 64'd1);
    rst = 1'b1; bus.we = 1'b1; bus.wR = 5'd5; bus.wD = 32'h1;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd8;
    tick(); rst = 1'b0; idle(); #1;
    chk("rst2_rd1", 64'(bus.rD1), 64'd0);
    chk("rst2_cnt", 64'(bus.busy_cnt), 64'd0);

    // Zero register ignores writes and issues.
    bus.we = 1'b1; bus.wR = 5'd0; bus.wD = 32'h1234;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0; bus.rR1 = 5'd0;
    #1;
    chk("zero_byp_rd1", 64'(bus.rD1), 64'd0);
    tick(); idle(); #1;
    chk("zero_rd1", 64'(bus.rD1), 64'd0);
    chk("zero_busy1", 64'(bus.rs1_busy), 64'd0);
    chk("zero_cnt", 64'(bus.busy_cnt), 64'd0);

    // Issue then writeback lifecycle.
    issue(5'd7);
    bus.rR1 = 5'd7; #1;
    chk("life_busy", 64'(bus.rs1_busy), 64'd1);
    chk("life_cnt1", 64'(bus.busy_cnt), 64'd1);
    bus.we = 1'b1; bus.wR = 5'd7; bus.wD = 32'hA5A5A5A5;
    tick(); idle(); #1;
    chk("life_clr", 64'(bus.rs1_busy), 64'd0);
    chk("life_data", 64'(bus.rD1), 64'hA5A5A5A5);
    chk("life_cnt0", 64'(bus.busy_cnt), 64'd0);

    // Same-edge issue and writeback to r9: stays busy, data updated.
    issue(5'd9);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    bus.we = 1'b1; bus.wR = 5'd9; bus.wD = 32'h99;
    tick(); idle();
    bus.rR1 = 5'd9; #1;
    chk("same_busy", 64'(bus.rs1_busy), 64'd1);
    chk("same_data", 64'(bus.rD1), 64'h99);
    chk("same_cnt", 64'(bus.busy_cnt), 64'd1);
    bus.we = 1'b1; bus.wR = 5'd9; bus.wD = 32'h99;
    tick(); idle(); #1;
    chk("r9_clr_cnt", 64'(bus.busy_cnt), 64'd0);

    // Re-issue of a busy register does not nest.
    issue(5'd10); issue(5'd10); #1;
    chk("nest_cnt", 64'(bus.busy_cnt), 64'd1);
    bus.we = 1'b1; bus.wR = 5'd10; bus.wD = 32'h0;
    tick(); idle(); #1;

    // Flush wins over issue; the writeback data still lands.
    issue(5'd1); issue(5'd2); issue(5'd3); #1;
    chk("pre_flush_cnt", 64'(bus.busy_cnt), 64'd3);
    bus.flush = 1'b1; bus.iss_valid = 1'b1; bus.iss_rd = 5'd4;
    bus.we = 1'b1; bus.wR = 5'd2; bus.wD = 32'h22;
    tick(); idle();
    bus.rR1 = 5'd4; bus.rR2 = 5'd2; #1;
    chk("flush_cnt", 64'(bus.busy_cnt), 64'd0);
    chk("flush_r4", 64'(bus.rs1_busy), 64'd0);
    chk("flush_wr", 64'(bus.rD2), 64'h22);

    // Write-through forwarding (or its absence).
    issue(5'd12);
    bus.we = 1'b1; bus.wR = 5'd12; bus.wD = 32'h55; bus.rR2 = 5'd12;
    #1;
`ifdef RF_BYPASS_EN
    chk("byp_rd2", 64'(bus.rD2), 64'h55);
    chk("byp_busy2", 64'(bus.rs2_busy), 64'd0);
`else
    chk("nobyp_rd2", 64'(bus.rD2), 64'h0);
    chk("nobyp_busy2", 64'(bus.rs2_busy), 64'd1);
`endif
    tick(); idle(); #1;
    chk("post_rd2", 64'(bus.rD2), 64'h55);
    chk("post_busy2", 64'(bus.rs2_busy), 64'd0);
    chk("post_cnt", 64'(bus.busy_cnt), 64'd0);

    // Fill every non-zero register: count tops out at 31.
    for (int i = 0; i < 32; i++) issue(5'(i));
    #1;
    chk("full_cnt", 64'(bus.busy_cnt), 64'd31);
    bus.flush = 1'b1;
    tick(); idle(); #1;
    chk("full_flush", 64'(bus.busy_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_sb.md
Name: rf_sb

Overview:
- Parametrised 2-read/1-write register file with an integrated per-register busy scoreboard.
- Successor to the single-cycle CPU register file, for the pipelined core.
- Decode reads operands and gets a busy (RAW hazard) flag per operand; issue marks the destination busy; writeback writes data and clears busy.
- Synchronous reset clears all registers and busy bits.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes, and is never busy.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- rR1  input  ADDR_W  read port 1 index.
- rD1  output  DATA_W  read port 1 data, combinational.
- rs1_busy  output  1  register rR1 has a pending write.
- rR2  input  ADDR_W  read port 2 index.
- rD2  output  DATA_W  read port 2 data, combinational.
- rs2_busy  output  1  register rR2 has a pending write.
- we  input  1  writeback enable.
- wR  input  ADDR_W  writeback index.
- wD  input  DATA_W  writeback data.
- iss_valid  input  1  an instruction with a destination issues this cycle.
- iss_rd  input  ADDR_W  destination index of the issuing instruction.
- flush  input  1  clear all busy bits; register data is kept.
- busy_cnt  output  ADDR_W+1  number of registers currently marked busy.

Behaviour:
- Reset (rst=1 at a clock edge): all registers are 0, all busy bits are 0, and busy_cnt is 0 after that edge. rst overrides we, iss_valid and flush in the same cycle.
- Read ports are combinational from array state. No read latency.
- With ZERO_REG=1 and index 0: rD=0 and busy=0, regardless of array contents or bypass.
- Write: when we=1 at a clock edge, regs[wR] takes wD. Writes to index 0 are dropped when ZERO_REG=1. When ZERO_REG=0, register 0 is an ordinary register.
- Busy bits:
  - Set at the clock edge when iss_valid=1, for index iss_rd (excluding index 0 when ZERO_REG=1).
  - Cleared at the clock edge when we=1, for index wR.
  - Same-edge issue and writeback to the same index: the bit stays 1, because the new producer wins.
  - Issue to an already-busy register: the bit stays 1 (no nesting count).
  - flush=1 clears every busy bit. flush has priority over an iss_valid in the same cycle, and that issue is dropped.
  - The write of wD still happens during flush.
- busy_cnt always equals the population count of the busy bits. It is updated registered, consistent with the busy bits after each edge. It never exceeds 2**ADDR_W, minus 1 when ZERO_REG=1.
- rs1_busy and rs2_busy are combinational from the busy bits and rR1/rR2.
- If reset is asserted mid-operation, pending busy state is discarded; there is no recovery.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: when we=1 and wR==rRn (excluding reg 0 when ZERO_REG=1), rDn=wD and rsn_busy=0 in that same cycle (write-through forwarding).
- Not defined: rDn shows the old value and rsn_busy stays as currently stored; the new data is visible the cycle after the write edge.

Decomposition:
- Package rf_pkg holds:
  - default DATA_W and ADDR_W constants;
  - the zero-index constant;
  - a popcount function used for busy_cnt.
- One sub-module, rf_busy_table, contains:
  - the busy-bit vector with its set/clear/flush priority logic;
  - the two busy lookups;
  - busy_cnt.
- The data array and bypass muxing stay in rf_sb.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, then assert rst for 1 cycle -> rD1=0 with rR1=5; busy_cnt=0.
- Zero register: we=1, wR=0, wD=0x1234, iss_valid=1, iss_rd=0 -> rD1 with rR1=0 is 0, rs1_busy=0, busy_cnt=0 (ZERO_REG=1).
- Scoreboard lifecycle:
  - issue rd=7 -> rs1_busy=1 with rR1=7, busy_cnt=1;
  - next cycle we=1, wR=7, wD=0xA5A5A5A5 -> after the edge rs1_busy=0, rD1=0xA5A5A5A5, busy_cnt=0.
- Same-cycle issue and writeback to r9 (r9 busy) -> r9 remains busy, its data is updated to wD, busy_cnt unchanged.
- Flush: issue r1, r2, r3 in consecutive cycles (busy_cnt=3), then flush=1 together with iss_valid=1, iss_rd=4 -> busy_cnt=0, r4 not busy.
- Bypass, with we=1, wR=12, wD=0x55, rR2=12, r12 busy, same cycle:
  - RF_BYPASS_EN defined -> rD2=0x55, rs2_busy=0;
  - not defined -> rD2 shows the old value, rs2_busy=1, then the next cycle rD2=0x55, rs2_busy=0.
